fetch_stage: RTL and testbench

- Instruction-fetch stage of the 8-bit pipelined processor. Owns the program counter and the IF/ID pipeline register.
- Generates the instruction-memory address, which is read combinationally. Computes PC+1 and selects the next PC from four sources: sequential, hold, branch redirect, or a vector loaded from memory.
- Handles the boot vector and the interrupt vector. Feeds decode.

---
 rtl/fetch_stage_pkg.sv | 44 ++++
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage_if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state and next-PC select
// codes, the NOP word, and the generic adder / 4:1 mux used by the PC datapath.
package fetch_defs;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_INT_VEC = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_INC    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_VEC    = 2'd3
  } pc_sel_t;

  // Helpers operate on a wide word; callers zero-extend in and truncate out.
  localparam int HW = 32;
  localparam logic [HW-1:0] NOP_INSTR = 32'd0;

  function automatic logic [HW-1:0] adder(input logic [HW-1:0] op1,
                                          input logic [HW-1:0] op2,
                                          input logic          carryin);
    return op1 + op2 + {31'd0, carryin};
  endfunction

  function automatic logic [HW-1:0] mux_4_1(input pc_sel_t         sel,
                                            input logic [HW-1:0] in0,
                                            input logic [HW-1:0] in1,
                                            input logic [HW-1:0] in2,
                                            input logic [HW-1:0] in3);
    logic [HW-1:0] res;
    case (sel)
      SEL_INC:    res = in0;
      SEL_HOLD:   res = in1;
      SEL_BRANCH: res = in2;
      SEL_VEC:    res = in3;
      default:    res = in1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its neighbours: instruction memory, hazard
// unit, execute redirect, interrupt controller and decode.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   stall;
  logic                   branch_taken;
  logic [ADDR_WIDTH-1:0]  branch_target;
  logic                   int_req;
  logic                   int_return;
  logic                   int_ack;
  logic [ADDR_WIDTH-1:0]  saved_pc;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic [ADDR_WIDTH-1:0]  if_id_pc_next;
  logic                   if_id_valid;

  modport master (
    output imem_addr, int_ack, saved_pc, if_id_instr, if_id_pc_next, if_id_valid,
    input  imem_data, stall, branch_taken, branch_target, int_req, int_return
  );

  modport slave (
    input  imem_addr, int_ack, saved_pc, if_id_instr, if_id_pc_next, if_id_valid,
    output imem_data, stall, branch_taken, branch_target, int_req, int_return
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, its PC+1 and a valid flag.
// bubble takes priority over load; with neither asserted the contents hold.
module if_id_reg
  import fetch_defs::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   bubble,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [ADDR_WIDTH-1:0]  pc_next_in,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc_next,
  output logic                   valid
);

  // Pipeline register with bubble insertion and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr   <= INSTR_WIDTH'(NOP_INSTR);
      pc_next <= {ADDR_WIDTH{1'b0}};
      valid   <= 1'b0;
    end else if (bubble) begin
      instr   <= INSTR_WIDTH'(NOP_INSTR);
      pc_next <= {ADDR_WIDTH{1'b0}};
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= instr_in;
      pc_next <= pc_next_in;
      valid   <= 1'b1;
    end else begin
      instr   <= instr;
      pc_next <= pc_next;
      valid   <= valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, boot/interrupt vector loading and the
// IF/ID register. Instruction memory is read combinationally at imem_addr.
module fetch_stage
  import fetch_defs::*;
#(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          INSTR_WIDTH = 8,
  parameter int unsigned BOOT_ADDR   = 32'd0,
  parameter int unsigned INT_ADDR    = 32'd1
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] saved_pc_r;
  logic                  int_active_r;

  pc_sel_t               sel_s;
  logic                  int_accept_s;
  logic                  load_s;
  logic                  bubble_s;
  logic [ADDR_WIDTH-1:0] imem_addr_s;
  logic [ADDR_WIDTH-1:0] pc_inc_s;
  logic [ADDR_WIDTH-1:0] pc_nxt_s;

  // Next-PC source, memory address and IF/ID control from state and requests.
  always_comb begin
    int_accept_s = (state_r == ST_RUN) && bus.int_req && !int_active_r &&
                   !bus.stall && !bus.branch_taken;
    sel_s        = SEL_HOLD;
    load_s       = 1'b0;
    bubble_s     = 1'b0;
    imem_addr_s  = pc_r;
    case (state_r)
      ST_BOOT: begin
        imem_addr_s = ADDR_WIDTH'(BOOT_ADDR);
        sel_s       = SEL_VEC;
        bubble_s    = 1'b1;
      end
      ST_RUN: begin
        if (bus.branch_taken) begin
          sel_s    = SEL_BRANCH;
          bubble_s = 1'b1;
        end else if (int_accept_s) begin
          // The instruction at pc is not issued; it is where RTI resumes.
          sel_s    = SEL_HOLD;
          bubble_s = 1'b1;
        end else if (bus.stall) begin
          sel_s    = SEL_HOLD;
        end else begin
          sel_s    = SEL_INC;
          load_s   = 1'b1;
        end
      end
      ST_INT_VEC: begin
        imem_addr_s = ADDR_WIDTH'(INT_ADDR);
        sel_s       = SEL_VEC;
        bubble_s    = 1'b1;
      end
      default: begin
        imem_addr_s = ADDR_WIDTH'(BOOT_ADDR);
        sel_s       = SEL_VEC;
        bubble_s    = 1'b1;
      end
    endcase
  end

  // PC+1 wraps modulo 2^ADDR_WIDTH; the carry-out is dropped by the truncation.
  always_comb begin
    pc_inc_s = ADDR_WIDTH'(adder(HW'(pc_r), {HW{1'b0}}, 1'b1));
    pc_nxt_s = ADDR_WIDTH'(mux_4_1(sel_s, HW'(pc_inc_s), HW'(pc_r),
                                   HW'(bus.branch_target), HW'(bus.imem_data)));
  end

  // Control state, PC and interrupt bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_BOOT;
      pc_r         <= {ADDR_WIDTH{1'b0}};
      saved_pc_r   <= {ADDR_WIDTH{1'b0}};
      int_active_r <= 1'b0;
    end else begin
      pc_r <= pc_nxt_s;
      case (state_r)
        ST_BOOT:    state_r <= ST_RUN;
        ST_RUN:     state_r <= int_accept_s ? ST_INT_VEC : ST_RUN;
        ST_INT_VEC: state_r <= ST_RUN;
        default:    state_r <= ST_BOOT;
      endcase
      if (int_accept_s) begin
        saved_pc_r   <= pc_r;
        int_active_r <= 1'b1;
      end else if (bus.int_return) begin
        int_active_r <= 1'b0;
      end
    end
  end

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .bubble    (bubble_s),
    .instr_in  (bus.imem_data),
    .pc_next_in(pc_inc_s),
    .instr     (bus.if_id_instr),
    .pc_next   (bus.if_id_pc_next),
    .valid     (bus.if_id_valid)
  );

  assign bus.imem_addr = imem_addr_s;
  assign bus.int_ack   = (state_r == ST_INT_VEC);
  assign bus.saved_pc  = saved_pc_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a combinational memory model
// holding mem[a] = a + 0x91 except the boot (0x10) and interrupt (0x80) vectors.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(8)) bus ();

  fetch_stage #(
    .ADDR_WIDTH (8),
    .INSTR_WIDTH(8),
    .BOOT_ADDR  (32'd0),
    .INT_ADDR   (32'd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] mem [256];
  assign bus.imem_data = mem[bus.imem_addr];

  typedef struct {
    logic       s, b, i, r;
    logic [7:0] t;
    logic [7:0] addr, instr, pcn;
    logic       valid, ack;
    logic [7:0] saved;
  } vec_t;

  vec_t vecs [26];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic s, input logic b, input logic [7:0] t,
                              input logic i, input logic r,
                              input logic [7:0] addr, input logic [7:0] instr,
                              input logic [7:0] pcn, input logic valid,
                              input logic ack, input logic [7:0] saved);
    vec_t v;
    v.s = s; v.b = b; v.t = t; v.i = i; v.r = r;
    v.addr = addr; v.instr = instr; v.pcn = pcn;
    v.valid = valid; v.ack = ack; v.saved = saved;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%02h, expected 0x%02h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [7:0] addr, input logic [7:0] instr,
                         input logic [7:0] pcn, input logic valid, input logic ack,
                         input logic [7:0] saved);
    chk("imem_addr", idx, bus.imem_addr, addr);
    chk("if_id_instr", idx, bus.if_id_instr, instr);
    chk("if_id_pc_next", idx, bus.if_id_pc_next, pcn);
    chk("if_id_valid", idx, {7'd0, bus.if_id_valid}, {7'd0, valid});
    chk("int_ack", idx, {7'd0, bus.int_ack}, {7'd0, ack});
    chk("saved_pc", idx, bus.saved_pc, saved);
  endtask

  task automatic drive(input logic s, input logic b, input logic [7:0] t,
                       input logic i, input logic r);
    bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
    bus.int_req = i; bus.int_return = r;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a + 32'h91);
    mem[0] = 8'h10;
    mem[1] = 8'h80;

    //                 s     b     tgt    i     r     addr   instr  pcn    vld   ack   saved
    vecs[0]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 8'hA1, 8'h11, 1'b1, 1'b0, 8'h00);
    vecs[1]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 8'hA2, 8'h12, 1'b1, 1'b0, 8'h00);
    vecs[2]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 8'hA2, 8'h12, 1'b1, 1'b0, 8'h00);
    vecs[3]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 8'hA2, 8'h12, 1'b1, 1'b0, 8'h00);
    vecs[4]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h13, 8'hA3, 8'h13, 1'b1, 1'b0, 8'h00);
    vecs[5]  = mk(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    vecs[6]  = mk(1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 8'hD1, 8'h41, 1'b1, 1'b0, 8'h00);
    vecs[8]  = mk(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    vecs[9]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 8'h33);
    vecs[10] = mk(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 8'h33);
    vecs[11] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h81, 8'h11, 8'h81, 1'b1, 1'b0, 8'h33);
    vecs[12] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h82, 8'h12, 8'h82, 1'b1, 1'b0, 8'h33);
    vecs[13] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h83, 8'h13, 8'h83, 1'b1, 1'b0, 8'h33);
    vecs[14] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 8'h83);
    vecs[15] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 8'h83);
    vecs[16] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h81, 8'h11, 8'h81, 1'b1, 1'b0, 8'h83);
    vecs[17] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h81, 8'h11, 8'h81, 1'b1, 1'b0, 8'h83);
    vecs[18] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 8'h81);
    vecs[19] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 8'h81);
    vecs[20] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h81, 8'h11, 8'h81, 1'b1, 1'b0, 8'h81);
    vecs[21] = mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h81);
    vecs[22] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h90, 8'h00, 1'b1, 1'b0, 8'h81);
    vecs[23] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h10, 8'h01, 1'b1, 1'b0, 8'h81);
    vecs[24] = mk(1'b0, 1'b1, 8'h54, 1'b0, 1'b0, 8'h54, 8'h00, 8'h00, 1'b0, 1'b0, 8'h81);
    vecs[25] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 8'hE5, 8'h55, 1'b1, 1'b0, 8'h81);

    // Reset state, then release between edges; BOOT shows address 0 first.
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    chk_all(100, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    #1;
    chk_all(101, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    chk_all(102, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 26; k++) begin
      drive(vecs[k].s, vecs[k].b, vecs[k].t, vecs[k].i, vecs[k].r);
      @(posedge clk); #1;
      chk_all(k, vecs[k].addr, vecs[k].instr, vecs[k].pcn, vecs[k].valid,
              vecs[k].ack, vecs[k].saved);
    end

    // Asynchronous reset between edges at pc=0x55 clears everything at once.
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk_all(200, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_all(201, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    #2 rst = 1'b0;
    // BOOT ignores stall, branch and interrupt requests.
    @(posedge clk); #1;
    chk_all(202, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all(203, 8'h11, 8'hA1, 8'h11, 1'b1, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
